// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: scheduler state codes, status bit positions and MMIO addresses.
package uart_tx_sched_pkg;
  typedef enum logic [1:0] {
    UTX_IDLE = 2'd0,
    UTX_SEND = 2'd1,
    UTX_WAIT = 2'd2
  } utx_state_e;
  localparam int UTX_ST_EMPTY = 8;
  localparam int UTX_ST_FULL = 9;
  localparam int UTX_ST_OVF = 10;
  localparam int UTX_ST_BUSY = 11;
  localparam logic [31:0] UART_ADDR = 32'h1000_0000;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h1000_0004;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; callers only pop when non-empty.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge CLK) if (push) mem_q[wr_ptr_q] <= wdata;
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: queues CPU UART stores and paces them to the core one frame apart.
// Define UART_TX_STALL_EN to request a pipeline stall instead of dropping bytes when full.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int FRAME_CYCLES = 10850
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        clr_ovf,
  output logic        uart_wr,
  output logic [7:0]  uart_dat,
  output logic [31:0] status,
  output logic        stall_req
);
  localparam int CW = $clog2(FRAME_CYCLES);
  utx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, uart_wr_q, uart_wr_d;
  logic [7:0] uart_dat_q, uart_dat_d, rdata;
  logic [AW:0] count;
  logic full, empty, pop, push;
  sync_fifo #(.DEPTH(DEPTH), .AW(AW), .WIDTH(8)) u_fifo (
    .CLK(CLK), .RST(RST), .push(push), .pop(pop), .wdata(wr_data),
    .rdata(rdata), .count(count), .full(full), .empty(empty)
  );
  always_comb begin
    pop = !empty && (state_q == UTX_IDLE || (state_q == UTX_WAIT && cnt_q == '0));
    push = wr_en && (!full || pop);
    ovf_d = (wr_en && full && !pop) || (ovf_q && !clr_ovf);
    uart_wr_d = pop;
    uart_dat_d = pop ? rdata : uart_dat_q;
    cnt_d = state_q == UTX_SEND ? CW'(FRAME_CYCLES - 2) :
            (state_q == UTX_WAIT && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    state_d = pop ? UTX_SEND :
              state_q == UTX_SEND ? UTX_WAIT :
              (state_q == UTX_WAIT && cnt_q == '0) ? UTX_IDLE : state_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= UTX_IDLE;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      uart_wr_q <= 1'b0;
      uart_dat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      uart_wr_q <= uart_wr_d;
      uart_dat_q <= uart_dat_d;
    end
  end
  always_comb begin
    status = '0;
    status[AW:0] = count;
    status[UTX_ST_EMPTY] = empty;
    status[UTX_ST_FULL] = full;
    status[UTX_ST_OVF] = ovf_q;
    status[UTX_ST_BUSY] = state_q != UTX_IDLE;
  end
  assign uart_wr = uart_wr_q;
  assign uart_dat = uart_dat_q;
`ifdef UART_TX_STALL_EN
  assign stall_req = full && !pop;
`else
  assign stall_req = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed checks of queuing, pacing, overflow and reset (DEPTH=4, FRAME_CYCLES=20).
module tb_uart_tx_sched;
  localparam int FR = 20;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, clr_ovf = 1'b0;
  logic [7:0] wr_data = '0;
  logic uart_wr, stall_req;
  logic [7:0] uart_dat;
  logic [31:0] status;
  int cyc = 0, t0 = 0, n_chk = 0, n_fail = 0, b;
  int wr_cyc[$];
  logic [7:0] wr_dat[$];
  uart_tx_sched #(.DEPTH(4), .AW(2), .FRAME_CYCLES(FR)) dut (
    .CLK(clk), .RST(rst), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
    .uart_wr(uart_wr), .uart_dat(uart_dat), .status(status), .stall_req(stall_req)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (uart_wr) begin
    wr_cyc.push_back(cyc - t0);
    wr_dat.push_back(uart_dat);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic go(input int k);
    while (cyc - t0 < k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    t0 = cyc;
    b = wr_cyc.size();
  endtask
  task automatic burst(input int start, input int n, input logic [7:0] base);
    go(start);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_data = base + 8'(i);
      go(start + i + 1);
    end
    wr_en = 1'b0;
  endtask
  task automatic pulses(input string tag, input int n, input logic [7:0] base);
    chk({tag, "_n"}, wr_cyc.size() - b, n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_cyc"}, (b + i < wr_cyc.size()) ? wr_cyc[b+i] : -1, 7 + FR * i);
      chk({tag, "_dat"}, (b + i < wr_dat.size()) ? {24'b0, wr_dat[b+i]} : 32'hffff_ffff, {24'b0, base + 8'(i)});
    end
  endtask
  initial begin
    do_reset();
    chk("rst_status", status, 32'h100);
    chk("rst_wr", {31'b0, uart_wr}, 0);
    chk("rst_dat", {24'b0, uart_dat}, 0);
    chk("rst_stall", {31'b0, stall_req}, 0);
    burst(5, 1, 8'h41);
    go(6);
    chk("t1_wr_c6", {31'b0, uart_wr}, 0);
    go(7);
    chk("t1_wr_c7", {31'b0, uart_wr}, 1);
    chk("t1_dat_c7", {24'b0, uart_dat}, 32'h41);
    go(26);
    chk("t1_busy_c26", {31'b0, status[11]}, 1);
    go(27);
    chk("t1_busy_c27", {31'b0, status[11]}, 0);
    go(40);
    pulses("t1", 1, 8'h41);
    do_reset();
    burst(5, 3, 8'h10);
    chk("t2_count_c8", status, 32'h802);
    go(46);
    chk("t2_empty_c46", {31'b0, status[8]}, 0);
    go(47);
    chk("t2_empty_c47", {31'b0, status[8]}, 1);
    go(70);
    pulses("t2", 3, 8'h10);
`ifndef UART_TX_STALL_EN
    do_reset();
    burst(5, 6, 8'ha0);
    chk("t3_status_c11", status, 32'he04);
    chk("t3_stall", {31'b0, stall_req}, 0);
    go(15);
    clr_ovf = 1'b1;
    chk("t3_ovf_c15", {31'b0, status[10]}, 1);
    go(16);
    clr_ovf = 1'b0;
    chk("t3_ovf_c16", {31'b0, status[10]}, 0);
    go(110);
    pulses("t3", 5, 8'ha0);
`else
    do_reset();
    begin
      int idx = 0, seen = 0;
      go(5);
      while (idx < 6 && cyc - t0 < 200) begin
        wr_en = 1'b1;
        wr_data = 8'hd0 + 8'(idx);
        if (stall_req) seen++;
        else idx++;
        go(cyc - t0 + 1);
      end
      wr_en = 1'b0;
      chk("t5_all_sent", idx, 6);
      chk("t5_stall_seen", {31'b0, seen > 0}, 1);
      chk("t5_ovf", {31'b0, status[10]}, 0);
      go(140);
      pulses("t5", 6, 8'hd0);
    end
`endif
    do_reset();
    burst(5, 5, 8'hb0);
    go(20);
    chk("t4_status_c20", status, 32'ha04);
    go(26);
    wr_en = 1'b1;
    wr_data = 8'hb5;
    go(27);
    wr_en = 1'b0;
    chk("t4_status_c27", status, 32'ha04);
    go(130);
    pulses("t4", 6, 8'hb0);
    chk("t4_empty", status, 32'h100);
    do_reset();
    burst(5, 3, 8'hc0);
    go(12);
    chk("t6_pre_count", status, 32'h802);
    rst = 1'b1;
    go(13);
    rst = 1'b0;
    chk("t6_status", status, 32'h100);
    chk("t6_wr", {31'b0, uart_wr}, 0);
    chk("t6_dat", {24'b0, uart_dat}, 0);
    chk("t6_stall", {31'b0, stall_req}, 0);
    go(53);
    pulses("t6", 1, 8'hc0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
